instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter IW, default 15, instruction word width in bits (9..16).
REQ-002 SHALL have parameter AW, default 8, instruction memory address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a load when sampled high in IDLE or DONE.
REQ-006 SHALL have port in_valid  input  1  byte source has a valid byte.
REQ-007 SHALL have port in_data  input  8  byte from the source.
REQ-008 SHALL have port in_ready  output  1  loader accepts the byte this cycle.
REQ-009 SHALL have port im_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 SHALL have port im_addr  output  AW  write address.
REQ-011 SHALL have port im_wdata  output  IW  write data.
REQ-012 SHALL have port cpu_hold  output  1  holds the CPU PC at 0 while high.
REQ-013 SHALL have port done  output  1  load completed without error.
REQ-014 SHALL have port err  output  1  load aborted: checksum mismatch.

Function
REQ-015 A byte SHALL transfer only on a cycle with in_valid and in_ready both high; in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 The states SHALL be IDLE, HDR, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 IDLE, DONE and ERR SHALL move to HDR on start; in_ready SHALL be high only in HDR, DATA and CSUM.
REQ-018 In HDR, the accepted byte SHALL set the word count N; 0 means 256 words; the next state SHALL be DATA.
REQ-019 In DATA, each word SHALL be 2 bytes, MSB first; bits above IW of the first byte SHALL be ignored.
REQ-020 After the second byte of a word, the FSM SHALL enter WRITE for exactly one cycle: im_we=1, im_addr=word index, im_wdata=assembled word.
REQ-021 The word index SHALL start at 0 and increment after each write, wrapping modulo 2^AW.
REQ-022 After WRITE, the FSM SHALL return to DATA if words remain, otherwise go to CSUM (macro defined) or DONE.
REQ-023 cpu_hold SHALL be high in every state except IDLE and DONE.
REQ-024 done SHALL be high exactly while in DONE; err SHALL be high exactly while in ERR.
REQ-025 A start asserted outside IDLE, DONE and ERR SHALL be ignored.
REQ-026 Idle source cycles (in_valid low) SHALL stall the FSM without changing any state.

Reset
REQ-027 While rst is sampled high, the FSM SHALL go to IDLE and clear the word index, count and byte registers; rst SHALL override start.
REQ-028 While in reset, in_ready, im_we, cpu_hold, done and err SHALL be 0, and im_addr and im_wdata SHALL be 0.
REQ-029 Reset mid-load SHALL abandon the load without any further im_we pulse; words already written SHALL remain in memory.

Configuration
REQ-030 The macro LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-031 With LOADER_CHECKSUM_EN defined:
- An 8-bit running XOR SHALL be kept of every byte accepted in HDR and DATA.
- After the last WRITE, one more byte SHALL be accepted in CSUM.
- If that byte equals the running XOR, the next state SHALL be DONE; otherwise ERR.
- ERR SHALL keep cpu_hold high.
REQ-032 Without LOADER_CHECKSUM_EN, the CSUM state, the running XOR and the ERR state SHALL be absent; err SHALL be tied to 0.

Verification
REQ-033 Normal load: rst, start, then bytes 02,00,0A,40,12 -> im_we at addr 0 with 000A, at addr 1 with 4012; then done=1 and cpu_hold=0.
REQ-034 Stalls: same stream with in_valid low for 3 cycles between every byte -> identical writes; no im_we during stalls.
REQ-035 Masking: bytes 01,FF,FF -> im_wdata=7FFF at addr 0.
REQ-036 Full count: header 00 followed by 512 bytes -> exactly 256 writes; addresses 0..255; done asserted.
REQ-037 Mid-load reset: rst after the first data byte -> no im_we; IDLE; cpu_hold=0; a following start restarts from addr 0.
REQ-038 Checksum (macro defined): 01,00,0A then 0B -> done; 01,00,0A then 0C -> err=1, cpu_hold=1, done=0.

Source files
------------

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream loader that writes instruction words into IMEM.
// Define LOADER_CHECKSUM_EN to append and verify a trailing XOR checksum byte.
module instr_loader #(
   parameter int IW = 15,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [IW-1:0] im_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM  = 3'd4,
      S_ERR   = 3'd6,
`endif
      S_DONE  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [8:0]    cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic [7:0]    hi_q, hi_d;
   logic [IW-1:0] word_q, word_d;
   logic          rdy;
   logic          accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    xor_q, xor_d;
`endif

   // Ready is a pure function of state so the source may wait on it.
`ifdef LOADER_CHECKSUM_EN
   assign rdy = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
   assign rdy = (state_q == S_HDR) || (state_q == S_DATA);
`endif
   assign accept = in_valid && rdy;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      hi_d    = hi_q;
      word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
      xor_d   = xor_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_HDR;
               idx_d   = '0;
               sel_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               xor_d   = 8'd0;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_ERR: begin
            if (start) begin
               state_d = S_HDR;
               idx_d   = '0;
               sel_d   = 1'b0;
               xor_d   = 8'd0;
            end
         end
`endif
         S_HDR: begin
            if (accept) begin
               cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
               state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
               xor_d   = xor_q ^ in_data;
`endif
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               xor_d = xor_q ^ in_data;
`endif
               if (!sel_q) begin
                  hi_d  = in_data;
                  sel_d = 1'b1;
               end else begin
                  // Truncation drops the first byte's bits above IW.
                  word_d  = IW'({hi_q, in_data});
                  sel_d   = 1'b0;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= 9'd0;
         sel_q   <= 1'b0;
         hi_q    <= 8'd0;
         word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         hi_q    <= hi_d;
         word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q   <= xor_d;
`endif
      end
   end

   // Outputs are forced quiet for the whole cycle rst is high, whatever the state.
   assign in_ready = !rst && rdy;
   assign im_we    = !rst && (state_q == S_WRITE);
   assign im_addr  = rst ? '0 : idx_q;
   assign im_wdata = rst ? '0 : word_q;
   assign cpu_hold = !rst && (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = !rst && (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
   assign err      = !rst && (state_q == S_ERR);
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader.
module tb_instr_loader;
   localparam int IW = 15;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [IW-1:0] im_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;

   instr_loader #(.IW(IW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [AW-1:0] wr_addr[$];
   logic [IW-1:0] wr_data[$];
   logic [7:0]    stim[$];

   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred.
   task automatic send_byte(input logic [7:0] b, input int stall);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (stall) @(negedge clk);
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      while (!(done === 1'b1 || err === 1'b1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("end_reached", 32'(done | err), 1);
   endtask

   task automatic run_stim(input int stall, input int mid_start, input logic [7:0] csum_add);
      logic [7:0] x;
      x = 8'd0;
      wr_addr.delete();
      wr_data.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("hold_in_hdr", 32'(cpu_hold), 1);
      foreach (stim[i]) begin
         x ^= stim[i];
         if (i == mid_start) start = 1'b1;
         send_byte(stim[i], stall);
         start = 1'b0;
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x + csum_add, stall);
`else
      if (csum_add != 8'd0) x = x + csum_add;
`endif
      wait_end();
   endtask

   task automatic check_two_words(input string tag);
      check({tag, "_nwr"}, wr_addr.size(), 2);
      if (wr_addr.size() >= 2) begin
         check({tag, "_a0"}, 32'(wr_addr[0]), 0);
         check({tag, "_d0"}, 32'(wr_data[0]), 32'h000A);
         check({tag, "_a1"}, 32'(wr_addr[1]), 1);
         check({tag, "_d1"}, 32'(wr_data[1]), 32'h4012);
      end
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_hold"}, 32'(cpu_hold), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      logic [15:0] exp_w;

      // Reset state, with start held to confirm reset wins.
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(in_ready), 0);
      check("rst_we", 32'(im_we), 0);
      check("rst_hold", 32'(cpu_hold), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_addr", 32'(im_addr), 0);
      check("rst_wdata", 32'(im_wdata), 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 0);
      check("idle_hold", 32'(cpu_hold), 0);

      // Normal load.
      stim = '{8'h02, 8'h00, 8'h0A, 8'h40, 8'h12};
      run_stim(0, -1, 8'd0);
      check_two_words("norm");

      // Stalled load restarted from DONE, with an ignored start mid-word.
      run_stim(3, 2, 8'd0);
      check_two_words("stall");

      // High bits of the first byte are masked.
      stim = '{8'h01, 8'hFF, 8'hFF};
      run_stim(0, -1, 8'd0);
      check("mask_nwr", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check("mask_a0", 32'(wr_addr[0]), 0);
         check("mask_d0", 32'(wr_data[0]), 32'h7FFF);
      end

      // Header 0 means 256 words.
      stim.delete();
      stim.push_back(8'h00);
      for (int i = 0; i < 256; i++) begin
         stim.push_back(8'(i));
         stim.push_back(~8'(i));
      end
      run_stim(0, -1, 8'd0);
      check("full_nwr", wr_addr.size(), 256);
      for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
         exp_w = {8'(i), ~8'(i)} & 16'h7FFF;
         check("full_addr", 32'(wr_addr[i]), i);
         check("full_data", 32'(wr_data[i]), 32'(exp_w));
      end
      check("full_done", 32'(done), 1);

      // Reset after the first data byte abandons the load.
      wr_addr.delete();
      wr_data.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(in_ready), 0);
      check("midrst_hold", 32'(cpu_hold), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_nwr", wr_addr.size(), 0);
      check("midrst_idle_hold", 32'(cpu_hold), 0);
      check("midrst_idle_ready", 32'(in_ready), 0);
      check("midrst_done", 32'(done), 0);
      stim = '{8'h01, 8'h12, 8'h34};
      run_stim(0, -1, 8'd0);
      check("restart_nwr", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check("restart_a0", 32'(wr_addr[0]), 0);
         check("restart_d0", 32'(wr_data[0]), 32'h1234);
      end

`ifdef LOADER_CHECKSUM_EN
      // 01 ^ 00 ^ 0A = 0B is the good checksum; 0C is bad.
      stim = '{8'h01, 8'h00, 8'h0A};
      run_stim(0, -1, 8'd0);
      check("csum_ok_done", 32'(done), 1);
      check("csum_ok_err", 32'(err), 0);
      run_stim(0, -1, 8'd1);
      check("csum_bad_err", 32'(err), 1);
      check("csum_bad_hold", 32'(cpu_hold), 1);
      check("csum_bad_done", 32'(done), 0);
      check("csum_bad_nwr", wr_addr.size(), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
